// File: rtl/axi4_lite_timer_master.sv
// AXI4-Lite initiator for the timer register block.
// Turns one local command into a single bus transaction and returns one response.
// A per-phase watchdog converts a hung slave into an error response.
module axi4_lite_timer_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  // local command side
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  // local response side
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  // write channel
  output logic [ADDR_W-1:0] o_awaddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_wvalid,
  input  logic              i_wready,
  input  logic              i_bvalid,
  output logic              o_bready,
  // read channel
  output logic [ADDR_W-1:0] o_araddr,
  output logic              o_rready,
  input  logic              i_rvalid,
  input  logic [DATA_W-1:0] i_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // Last wait cycle of a phase; a missing handshake on this edge is a timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_RESP,
    S_RD,
    S_RESP
  } state_t;

  state_t            r_state,     w_state_next;
  logic [CNT_W-1:0]  r_cnt,       w_cnt_next;
  logic              r_wvalid,    w_wvalid_next;
  logic              r_bready,    w_bready_next;
  logic              r_rready,    w_rready_next;
  logic              r_rsp_valid, w_rsp_valid_next;
  logic              r_rsp_err,   w_rsp_err_next;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_next;
  logic [ADDR_W-1:0] r_awaddr,    w_awaddr_next;
  logic [DATA_W-1:0] r_wdata,     w_wdata_next;
  logic [ADDR_W-1:0] r_araddr,    w_araddr_next;

  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_expired;

  // Saturating watchdog increment and expiry detect.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_expired = (r_cnt >= CNT_LAST);

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_awaddr    = r_awaddr;
  assign o_wdata     = r_wdata;
  assign o_wvalid    = r_wvalid;
  assign o_bready    = r_bready;
  assign o_araddr    = r_araddr;
  assign o_rready    = r_rready;

  // State and registered outputs; reset drops every handshake at once.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_araddr    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_wvalid    <= w_wvalid_next;
      r_bready    <= w_bready_next;
      r_rready    <= w_rready_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_err   <= w_rsp_err_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_awaddr    <= w_awaddr_next;
      r_wdata     <= w_wdata_next;
      r_araddr    <= w_araddr_next;
    end
  end

  // Next-state and next-output decode; a handshake is checked before expiry so it wins.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_wvalid_next    = r_wvalid;
    w_bready_next    = r_bready;
    w_rready_next    = r_rready;
    w_rsp_valid_next = r_rsp_valid;
    w_rsp_err_next   = r_rsp_err;
    w_rsp_rdata_next = r_rsp_rdata;
    w_awaddr_next    = r_awaddr;
    w_wdata_next     = r_wdata;
    w_araddr_next    = r_araddr;

    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_cnt_next = '0;
          if (i_cmd_write) begin
            w_awaddr_next = i_cmd_addr;
            w_wdata_next  = i_cmd_wdata;
            w_wvalid_next = 1'b1;
            w_state_next  = S_WR_DATA;
          end else begin
            w_araddr_next = i_cmd_addr;
            w_rready_next = 1'b1;
            w_state_next  = S_RD;
          end
        end
      end

      S_WR_DATA: begin
        if (r_wvalid && i_wready) begin
          w_wvalid_next = 1'b0;
          w_bready_next = 1'b1;
          w_cnt_next    = '0;
          w_state_next  = S_WR_RESP;
        end else if (w_expired) begin
          w_wvalid_next    = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_err_next   = 1'b1;
          w_rsp_rdata_next = '0;
          w_state_next     = S_RESP;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      S_WR_RESP: begin
        if (r_bready && i_bvalid) begin
          w_bready_next    = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_err_next   = 1'b0;
          w_rsp_rdata_next = '0;
          w_state_next     = S_RESP;
        end else if (w_expired) begin
          w_bready_next    = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_err_next   = 1'b1;
          w_rsp_rdata_next = '0;
          w_state_next     = S_RESP;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      S_RD: begin
        if (r_rready && i_rvalid) begin
          w_rready_next    = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_err_next   = 1'b0;
          w_rsp_rdata_next = i_rdata;
          w_state_next     = S_RESP;
        end else if (w_expired) begin
          w_rready_next    = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_err_next   = 1'b1;
          w_rsp_rdata_next = '0;
          w_state_next     = S_RESP;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      S_RESP: begin
        if (i_rsp_ready) begin
          w_rsp_valid_next = 1'b0;
          w_state_next     = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule
